// File: rtl/gtfraw_axil_cmd_sequencer.sv
// AXI4-Lite master that executes write / read / poll / delay commands one at a time.
// Optional bus watchdog with HALT state: define GTFRAW_AXIL_SEQ_WATCHDOG_EN.
module gtfraw_axil_cmd_sequencer #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int POLL_MAX       = 1024,
    parameter int POLL_GAP       = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_areset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_data,
    input  logic [DATA_W-1:0]   cmd_mask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [1:0]          rsp_err,
    output logic                busy,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);
    localparam int ATT_W = $clog2(POLL_MAX + 1);
    localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, POLL_WAIT, DELAY, RSP, HALT
    } state_t;

    typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_POLL, OP_DELAY} op_t;

    state_t              state, state_nxt;
    op_t                 op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q, mask_q, dly_cnt;
    logic [ATT_W-1:0]    attempt;
    logic [GAP_W-1:0]    gap_cnt;
    logic                awvalid_q, wvalid_q, arvalid_q;
    logic                accept, poll_match, poll_retry, wd_timeout, halt_q;

    assign accept     = (state == IDLE) && cmd_valid;
    assign poll_match = (m_axi_rdata & mask_q) == (data_q & mask_q);
    // A poll read that is clean, unmatched and not the last attempt loops back.
    assign poll_retry = (op_q == OP_POLL) && (m_axi_rresp == 2'd0) && !poll_match
                        && (attempt != ATT_W'(POLL_MAX));

    assign cmd_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign rsp_valid     = (state == RSP);
    assign m_axi_bready  = (state == WR_RESP);
    assign m_axi_rready  = (state == RD_DATA);
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = data_q;
    assign m_axi_wstrb   = '1;

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: if (cmd_valid) begin
                case (op_t'(cmd_op))
                    OP_WRITE: state_nxt = WR_REQ;
                    OP_DELAY: state_nxt = (cmd_data == '0) ? RSP : DELAY;
                    default:  state_nxt = RD_REQ;
                endcase
            end
            WR_REQ:    if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready))
                           state_nxt = WR_RESP;
            WR_RESP:   if (m_axi_bvalid) state_nxt = RSP;
            RD_REQ:    if (m_axi_arready) state_nxt = RD_DATA;
            RD_DATA:   if (m_axi_rvalid) begin
                if (!poll_retry)        state_nxt = RSP;
                else if (POLL_GAP == 0) state_nxt = RD_REQ;
                else                    state_nxt = POLL_WAIT;
            end
            POLL_WAIT: if (gap_cnt == GAP_W'(1)) state_nxt = RD_REQ;
            DELAY:     if (dly_cnt == DATA_W'(1)) state_nxt = RSP;
            RSP:       if (rsp_ready) state_nxt = halt_q ? HALT : IDLE;
            HALT:      state_nxt = HALT;
            default:   state_nxt = IDLE;
        endcase
        if (wd_timeout) state_nxt = RSP;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            op_q      <= OP_WRITE;
            addr_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            dly_cnt   <= '0;
            attempt   <= '0;
            gap_cnt   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 2'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q      <= op_t'(cmd_op);
                    addr_q    <= cmd_addr;
                    data_q    <= cmd_data;
                    mask_q    <= cmd_mask;
                    dly_cnt   <= cmd_data;
                    attempt   <= ATT_W'(1);
                    rsp_data  <= '0;
                    rsp_err   <= 2'd0;
                    awvalid_q <= (op_t'(cmd_op) == OP_WRITE);
                    wvalid_q  <= (op_t'(cmd_op) == OP_WRITE);
                    arvalid_q <= (op_t'(cmd_op) == OP_READ) || (op_t'(cmd_op) == OP_POLL);
                end
                WR_REQ: begin
                    if (m_axi_awready) awvalid_q <= 1'b0;
                    if (m_axi_wready)  wvalid_q  <= 1'b0;
                end
                WR_RESP: if (m_axi_bvalid) rsp_err <= (m_axi_bresp != 2'd0) ? 2'd1 : 2'd0;
                RD_REQ:  if (m_axi_arready) arvalid_q <= 1'b0;
                RD_DATA: if (m_axi_rvalid) begin
                    rsp_data <= m_axi_rdata;
                    if (m_axi_rresp != 2'd0)
                        rsp_err <= 2'd1;
                    else if (op_q == OP_POLL && !poll_match && attempt == ATT_W'(POLL_MAX))
                        rsp_err <= 2'd2;
                    else
                        rsp_err <= 2'd0;
                    if (poll_retry) begin
                        if (POLL_GAP == 0) begin
                            arvalid_q <= 1'b1;
                            attempt   <= attempt + 1'b1;
                        end else begin
                            gap_cnt   <= GAP_W'(POLL_GAP);
                        end
                    end
                end
                POLL_WAIT: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == GAP_W'(1)) begin
                        arvalid_q <= 1'b1;
                        attempt   <= attempt + 1'b1;
                    end
                end
                DELAY:   dly_cnt <= dly_cnt - 1'b1;
                default: ;
            endcase
            if (wd_timeout) begin
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                arvalid_q <= 1'b0;
                rsp_err   <= 2'd3;
            end
        end
    end

`ifdef GTFRAW_AXIL_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_active, halt_r;

    assign wd_active  = (state == WR_REQ) || (state == WR_RESP) ||
                        (state == RD_REQ) || (state == RD_DATA);
    assign wd_timeout = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign halt_q     = halt_r;

    // Counts cycles spent in the current bus-wait state; any state change restarts it.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            wd_cnt <= '0;
            halt_r <= 1'b0;
        end else begin
            if (!wd_active || state_nxt != state) wd_cnt <= '0;
            else                                  wd_cnt <= wd_cnt + 1'b1;
            if (wd_timeout) halt_r <= 1'b1;
        end
    end
`else
    assign wd_timeout = 1'b0;
    assign halt_q     = 1'b0;
`endif

endmodule

// File: tb/tb_gtfraw_axil_cmd_sequencer.sv
// Directed bench for gtfraw_axil_cmd_sequencer with a latency-configurable AXI-Lite slave model.
module tb_gtfraw_axil_cmd_sequencer;
    localparam int AW = 32, DW = 32, PM = 5, PG = 4, TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0, cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0, cmd_mask = '0;
    logic          rsp_valid, rsp_ready = 1'b0, busy;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_err;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [DW-1:0] m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic          m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
    logic          m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
    logic          m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
    logic [1:0]    m_axi_bresp = 2'd0, m_axi_rresp = 2'd0;
    logic [DW-1:0] m_axi_rdata = '0;

    gtfraw_axil_cmd_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .POLL_MAX(PM), .POLL_GAP(PG), .TIMEOUT_CYCLES(TO)
    ) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    int n_vec = 0, n_err = 0;

    // Slave knobs and read-data table, indexed by the read handshake count.
    int            aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
    bit            b_en = 1'b1;
    logic [1:0]    bresp_cfg = 2'd0;
    logic [DW-1:0] rdata_tab [8];
    logic [1:0]    rresp_tab [8];
    int            aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;

    // Observed bus activity, cleared by a one-cycle clr_stats pulse.
    logic          clr_stats = 1'b0;
    int            cyc = 0, aw_hs, w_hs, ar_hs, r_hs, b_hs, rd_idx, any_valid_cyc;
    int            r_wait, bready_cyc, last_ar_cyc, min_ar_gap;
    logic [AW-1:0] last_awaddr, last_araddr;
    logic [DW-1:0] last_wdata;
    logic [DW/8-1:0] last_wstrb;

    always @(negedge clk) begin
        aw_cnt        <= m_axi_awvalid ? aw_cnt + 1 : 0;
        m_axi_awready <= m_axi_awvalid && (aw_cnt >= aw_lat);
        w_cnt         <= m_axi_wvalid ? w_cnt + 1 : 0;
        m_axi_wready  <= m_axi_wvalid && (w_cnt >= w_lat);
        ar_cnt        <= m_axi_arvalid ? ar_cnt + 1 : 0;
        m_axi_arready <= m_axi_arvalid && (ar_cnt >= ar_lat);
        r_cnt         <= m_axi_rready ? r_cnt + 1 : 0;
        m_axi_rvalid  <= m_axi_rready && (r_cnt >= r_lat);
        m_axi_rdata   <= rdata_tab[rd_idx % 8];
        m_axi_rresp   <= rresp_tab[rd_idx % 8];
        m_axi_bvalid  <= m_axi_bready && b_en;
        m_axi_bresp   <= bresp_cfg;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr_stats) begin
            aw_hs <= 0; w_hs <= 0; ar_hs <= 0; r_hs <= 0; b_hs <= 0; rd_idx <= 0;
            any_valid_cyc <= 0; r_wait <= 0; bready_cyc <= 0;
            last_ar_cyc <= 0; min_ar_gap <= 1000;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin aw_hs <= aw_hs + 1; last_awaddr <= m_axi_awaddr; end
            if (m_axi_wvalid && m_axi_wready) begin
                w_hs <= w_hs + 1; last_wdata <= m_axi_wdata; last_wstrb <= m_axi_wstrb;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                if (ar_hs != 0 && (cyc - last_ar_cyc) < min_ar_gap) min_ar_gap <= cyc - last_ar_cyc;
                last_ar_cyc <= cyc;
                last_araddr <= m_axi_araddr;
                ar_hs <= ar_hs + 1;
            end
            if (m_axi_rvalid && m_axi_rready) begin r_hs <= r_hs + 1; rd_idx <= rd_idx + 1; end
            if (m_axi_rready && !m_axi_rvalid) r_wait <= r_wait + 1;
            if (m_axi_bvalid && m_axi_bready) b_hs <= b_hs + 1;
            if (m_axi_bready) bready_cyc <= bready_cyc + 1;
            if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) any_valid_cyc <= any_valid_cyc + 1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1);
    end

    task automatic clear_stats();
        @(negedge clk); clr_stats = 1'b1;
        @(negedge clk); clr_stats = 1'b0;
    endtask

    // Returns at the negedge after the accepting edge; acc_cyc is the cycle count at that point.
    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [DW-1:0] mask,
                            output bit ok, output int acc_cyc);
        @(negedge clk);
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask; cmd_valid = 1'b1;
        ok = 1'b0; acc_cyc = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (cmd_ready) begin @(posedge clk); ok = 1'b1; end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_rsp(input int budget, output bit ok, output int rsp_cyc);
        ok = 1'b0; rsp_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid) begin ok = 1'b1; rsp_cyc = cyc; break; end
            @(negedge clk);
        end
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_vec++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin
            n_err++; $display("FAIL rst_axi_ctrl: got %b want 00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready});
        end
        n_vec++; if (rsp_data !== '0 || rsp_err !== 2'd0) begin
            n_err++; $display("FAIL rst_rsp_fields: got %h/%0d want 0/0", rsp_data, rsp_err);
        end
        n_vec++; if (m_axi_awaddr !== '0 || m_axi_wdata !== '0 || m_axi_araddr !== '0) begin
            n_err++; $display("FAIL rst_addr_data: got %h/%h/%h want 0", m_axi_awaddr, m_axi_wdata, m_axi_araddr);
        end
        clear_stats();
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_write();
        int            al [3] = '{0, 0, 3};
        int            wl [3] = '{2, 0, 0};
        logic [1:0]    br [3] = '{2'd0, 2'd2, 2'd0};
        logic [AW-1:0] ad [3] = '{32'h10, 32'h14, 32'h18};
        logic [DW-1:0] wd [3] = '{32'h0000_0001, 32'hCAFE_0000, 32'h0000_BEEF};
        logic [1:0]    ee [3] = '{2'd0, 2'd1, 2'd0};
        bit ok; int acc, rc;
        for (int i = 0; i < 3; i++) begin
            aw_lat = al[i]; w_lat = wl[i]; bresp_cfg = br[i];
            clear_stats();
            send_cmd(2'd0, ad[i], wd[i], '0, ok, acc);
            wait_rsp(100, ok, rc);
            n_vec++; if (!ok) begin n_err++; $display("FAIL wr%0d_rsp: got none want rsp_valid", i); end
            n_vec++; if (aw_hs !== 1 || w_hs !== 1 || b_hs !== 1) begin
                n_err++; $display("FAIL wr%0d_hs: got aw=%0d w=%0d b=%0d want 1/1/1", i, aw_hs, w_hs, b_hs);
            end
            n_vec++; if (last_awaddr !== ad[i] || last_wdata !== wd[i] || last_wstrb !== 4'hF) begin
                n_err++; $display("FAIL wr%0d_bus: got %h/%h/%h want %h/%h/f", i, last_awaddr,
                    last_wdata, last_wstrb, ad[i], wd[i]);
            end
            n_vec++; if (rsp_err !== ee[i] || rsp_data !== '0) begin
                n_err++; $display("FAIL wr%0d_rsp_fields: got %0d/%h want %0d/0", i, rsp_err, rsp_data, ee[i]);
            end
            ack_rsp();
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr%0d_busy_after: got %b want 0", i, busy); end
        end
        bresp_cfg = 2'd0; aw_lat = 0; w_lat = 0;
    endtask

    task automatic test_read();
        bit ok; int acc, rc;
        ar_lat = 1; r_lat = 2;
        rdata_tab[0] = 32'hA5A5_0003; rresp_tab[0] = 2'd0;
        rdata_tab[1] = 32'hDEAD_0000; rresp_tab[1] = 2'd2;
        clear_stats();
        send_cmd(2'd1, 32'h40, '0, '0, ok, acc);
        wait_rsp(100, ok, rc);
        n_vec++; if (!ok || rsp_data !== 32'hA5A5_0003 || rsp_err !== 2'd0) begin
            n_err++; $display("FAIL rd_ok: got %b %h/%0d want 1 a5a50003/0", ok, rsp_data, rsp_err);
        end
        n_vec++; if (ar_hs !== 1 || last_araddr !== 32'h40) begin
            n_err++; $display("FAIL rd_ar: got %0d@%h want 1@40", ar_hs, last_araddr);
        end
        n_vec++; if (r_wait !== 2) begin n_err++; $display("FAIL rd_rready_wait: got %0d want 2", r_wait); end
        ack_rsp();
        send_cmd(2'd1, 32'h44, '0, '0, ok, acc);
        wait_rsp(100, ok, rc);
        n_vec++; if (!ok || rsp_data !== 32'hDEAD_0000 || rsp_err !== 2'd1) begin
            n_err++; $display("FAIL rd_slverr: got %b %h/%0d want 1 dead0000/1", ok, rsp_data, rsp_err);
        end
        ack_rsp();
        rresp_tab[1] = 2'd0; ar_lat = 0; r_lat = 0;
    endtask

    task automatic test_poll();
        bit ok; int acc, rc;
        // Status bit 0 appears on the third read.
        rdata_tab[0] = 32'h10; rdata_tab[1] = 32'h20; rdata_tab[2] = 32'h21;
        clear_stats();
        send_cmd(2'd2, 32'h40, 32'h1, 32'h1, ok, acc);
        wait_rsp(300, ok, rc);
        n_vec++; if (!ok || ar_hs !== 3 || rsp_err !== 2'd0 || rsp_data !== 32'h21) begin
            n_err++; $display("FAIL poll_match: got %b ar=%0d %0d/%h want 1 ar=3 0/21", ok, ar_hs, rsp_err, rsp_data);
        end
        n_vec++; if (min_ar_gap < PG + 1) begin
            n_err++; $display("FAIL poll_gap: got %0d want >= %0d", min_ar_gap, PG + 1);
        end
        ack_rsp();
        // Never matches: five reads, last read data returned.
        for (int i = 0; i < 8; i++) rdata_tab[i] = 32'h100 + 2 * i;
        clear_stats();
        send_cmd(2'd2, 32'h40, 32'h1, 32'h1, ok, acc);
        wait_rsp(500, ok, rc);
        n_vec++; if (!ok || ar_hs !== PM || rsp_err !== 2'd2 || rsp_data !== 32'h108) begin
            n_err++; $display("FAIL poll_exhaust: got %b ar=%0d %0d/%h want 1 ar=5 2/108", ok, ar_hs, rsp_err, rsp_data);
        end
        ack_rsp();
        // Error response aborts on the first read.
        rresp_tab[0] = 2'd2;
        clear_stats();
        send_cmd(2'd2, 32'h40, 32'h1, 32'h1, ok, acc);
        wait_rsp(300, ok, rc);
        n_vec++; if (!ok || ar_hs !== 1 || rsp_err !== 2'd1) begin
            n_err++; $display("FAIL poll_slverr: got %b ar=%0d err=%0d want 1 ar=1 err=1", ok, ar_hs, rsp_err);
        end
        ack_rsp();
        rresp_tab[0] = 2'd0;
        // Only masked bits compare: 0x3A & 0xF0 == 0x35 & 0xF0.
        rdata_tab[0] = 32'h3A;
        clear_stats();
        send_cmd(2'd2, 32'h48, 32'h35, 32'hF0, ok, acc);
        wait_rsp(300, ok, rc);
        n_vec++; if (!ok || ar_hs !== 1 || rsp_err !== 2'd0 || rsp_data !== 32'h3A) begin
            n_err++; $display("FAIL poll_mask: got %b ar=%0d %0d/%h want 1 ar=1 0/3a", ok, ar_hs, rsp_err, rsp_data);
        end
        ack_rsp();
    endtask

    task automatic test_delay();
        bit ok; int acc, rc;
        clear_stats();
        send_cmd(2'd3, 32'h0, 32'd10, '0, ok, acc);
        wait_rsp(100, ok, rc);
        // Response is 11 cycles after the accept cycle, i.e. 10 edges after the accepting edge.
        n_vec++; if (!ok || (rc - acc) !== 10) begin
            n_err++; $display("FAIL delay10_latency: got %b %0d want 1 10", ok, rc - acc);
        end
        n_vec++; if (any_valid_cyc !== 0) begin
            n_err++; $display("FAIL delay_bus_quiet: got %0d valid cycles want 0", any_valid_cyc);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== '0 || rsp_err !== 2'd0 || cmd_ready !== 1'b0) begin
                n_err++; $display("FAIL delay_hold%0d: got v=%b %h/%0d rdy=%b want 1 0/0 0",
                    i, rsp_valid, rsp_data, rsp_err, cmd_ready);
            end
            @(negedge clk);
        end
        ack_rsp();
        n_vec++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL delay_done: got busy=%b rdy=%b want 0/1", busy, cmd_ready);
        end
        send_cmd(2'd3, 32'h0, 32'd0, '0, ok, acc);
        wait_rsp(20, ok, rc);
        n_vec++; if (!ok || (rc - acc) !== 0) begin
            n_err++; $display("FAIL delay0_latency: got %b %0d want 1 0", ok, rc - acc);
        end
        ack_rsp();
    endtask

    task automatic test_back_to_back();
        bit ok; int acc, rc;
        rdata_tab[0] = 32'h1234_5678; rdata_tab[1] = 32'h0BAD_F00D;
        clear_stats();
        send_cmd(2'd1, 32'h50, '0, '0, ok, acc);
        wait_rsp(100, ok, rc);
        cmd_op = 2'd1; cmd_addr = 32'h54; cmd_valid = 1'b1; rsp_ready = 1'b1;
        n_vec++; if (cmd_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_no_accept_in_rsp: got %b want 0", cmd_ready);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        n_vec++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle: got rdy=%b v=%b want 1/0", cmd_ready, rsp_valid);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(100, ok, rc);
        n_vec++; if (!ok || rsp_data !== 32'h0BAD_F00D || ar_hs !== 2 || last_araddr !== 32'h54) begin
            n_err++; $display("FAIL b2b_second: got %b %h ar=%0d@%h want 1 0badf00d ar=2@54",
                ok, rsp_data, ar_hs, last_araddr);
        end
        ack_rsp();
    endtask

    task automatic test_reset_midflight();
        bit ok; int acc;
        aw_lat = 1000; w_lat = 1000;
        send_cmd(2'd0, 32'h60, 32'h5, '0, ok, acc);
        repeat (2) @(negedge clk);
        n_vec++; if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1) begin
            n_err++; $display("FAIL midrst_pending: got %b%b want 11", m_axi_awvalid, m_axi_wvalid);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midrst_drop: got %b%b busy=%b want 00 0", m_axi_awvalid, m_axi_wvalid, busy);
        end
        @(negedge clk); rst = 1'b0;
        aw_lat = 0; w_lat = 0;
    endtask

`ifdef GTFRAW_AXIL_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        bit ok; int acc, rc;
        b_en = 1'b0;
        clear_stats();
        send_cmd(2'd0, 32'h70, 32'h1, '0, ok, acc);
        wait_rsp(400, ok, rc);
        n_vec++; if (!ok || rsp_err !== 2'd3) begin
            n_err++; $display("FAIL wd_rsp: got %b err=%0d want 1 err=3", ok, rsp_err);
        end
        n_vec++; if (bready_cyc !== TO) begin
            n_err++; $display("FAIL wd_wait_cycles: got %0d want %0d", bready_cyc, TO);
        end
        ack_rsp();
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++; $display("FAIL wd_halt%0d: got rdy=%b busy=%b want 0/1", i, cmd_ready, busy);
            end
            @(negedge clk);
        end
        b_en = 1'b1;
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_vec++; if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL wd_reset_release: got %b want 1", cmd_ready);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) begin rdata_tab[i] = '0; rresp_tab[i] = 2'd0; end
        test_reset();
        test_write();
        test_read();
        test_poll();
        test_delay();
        test_back_to_back();
        test_reset_midflight();
`ifdef GTFRAW_AXIL_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gtfraw_axil_cmd_sequencer.md
Name: gtfraw_axil_cmd_sequencer

Overview:
- AXI4-Lite master that turns a simple command stream (write / read / poll / delay) into single-beat AXI-Lite transactions.
- Sits directly upstream of the GTFRAW soft register slave and drives its s_axi_* port.
- Used by bring-up logic to pulse ctl_gt_reset_all and wait for stat_rx_status without a processor.
- One transaction in flight; one response per accepted command.

Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width; wstrb width = DATA_W/8
- POLL_MAX, 1024, maximum reads per poll command (>=1)
- POLL_GAP, 16, idle cycles between poll reads (0 allowed)
- TIMEOUT_CYCLES, 4096, watchdog limit (used only with the optional feature)

Ports:
- s_axi_aclk  in  1  single clock
- s_axi_areset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  0=write, 1=read, 2=poll, 3=delay
- cmd_addr  in  ADDR_W  target address
- cmd_data  in  DATA_W  write data / poll expected value / delay cycle count
- cmd_mask  in  DATA_W  poll compare mask
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_data  out  DATA_W  read data or last poll read; 0 for write and delay
- rsp_err  out  2  0=OK, 1=SLVERR/DECERR, 2=poll exhausted, 3=watchdog
- busy  out  1  high whenever state != IDLE
- m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master, widths per ADDR_W/DATA_W, resp 2 bits

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; all valids, bready, rready and rsp_valid = 0; rsp_data, rsp_err, addresses and data = 0; busy = 0.
- cmd_ready = (state == IDLE), combinational from the state register. Command fields are latched on acceptance.
- Write (op 0):
  - Cycle after accept: awvalid and wvalid rise together; wstrb all ones.
  - Each valid drops independently on its own handshake.
  - Enter WR_RESP once both handshakes are done; awready/wready may arrive in any order or the same cycle.
  - bready = 1 in WR_RESP.
  - On the bvalid handshake: rsp_valid rises next cycle; rsp_err = 1 if bresp != 0, else 0.
- Read (op 1):
  - Cycle after accept: arvalid = 1; drops on arready.
  - rready = 1 in RD_DATA.
  - On the rvalid handshake: next cycle rsp_valid = 1, rsp_data = rdata, rsp_err = 1 if rresp != 0.
- Poll (op 2):
  - Read loop on cmd_addr; the attempt counter starts at 1.
  - Each read is tested with (rdata & mask) == (data & mask).
  - Match: response with rsp_err = 0 and rsp_data = rdata.
  - Non-zero rresp: abort immediately with rsp_err = 1.
  - Attempt == POLL_MAX without a match: rsp_err = 2, rsp_data = last rdata.
  - Otherwise wait POLL_GAP cycles in POLL_WAIT, then reissue arvalid.
- Delay (op 3):
  - Count cmd_data cycles with no bus activity, then respond OK.
  - cmd_data = 0 responds on the cycle after accept.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, POLL_WAIT, DELAY, RSP, HALT.
- RSP holds rsp_valid and all rsp fields stable until rsp_ready, then returns to IDLE. A new command cannot be accepted in the RSP handshake cycle.
- AXI outputs are stable while valid is high and not yet accepted.
- Reset mid-transaction drops every valid at once; the slave is expected to be reset on the same reset.
- Counters are wide enough for POLL_MAX, POLL_GAP and DATA_W-bit delays; no wrap-around.

Optional Feature:
- Macro: GTFRAW_AXIL_SEQ_WATCHDOG_EN.
- With the macro defined:
  - A counter runs while in WR_REQ, WR_RESP, RD_REQ or RD_DATA and clears on every state change.
  - On reaching TIMEOUT_CYCLES: all AXI valids/readies drop, a response is issued with rsp_err = 3, and after rsp_ready the FSM enters HALT.
  - HALT holds cmd_ready = 0 and busy = 1 until reset.
- Without the macro: no counter and no HALT entry; a hung slave stalls the block indefinitely.

Test Plan:
- Write 0x0000_0001 to 0x0010, slave awready 2 cycles before wready -> one AW and one W handshake, rsp_err = 0, rsp_data = 0, busy returns to 0.
- Read 0x0040 with rdata 0xA5A5_0003 -> rsp_data = 0xA5A5_0003, rsp_err = 0; rready held until rvalid.
- Poll 0x0040, mask 0x1, data 0x1, POLL_GAP = 4; status bit set on the 3rd read -> exactly 3 AR handshakes, >=4 idle cycles between them, rsp_err = 0.
- Poll that never matches with POLL_MAX = 5 -> exactly 5 reads, rsp_err = 2, rsp_data = 5th rdata; read with rresp = 2 -> rsp_err = 1.
- Delay 10 -> rsp_valid 11 cycles after accept, no AXI valids; rsp_ready held low 3 cycles -> rsp stable and cmd_ready = 0 throughout.
- With GTFRAW_AXIL_SEQ_WATCHDOG_EN and TIMEOUT_CYCLES = 64, slave never asserts bvalid -> rsp_err = 3 after 64 cycles in WR_RESP, then cmd_ready stuck at 0 until s_axi_areset.
